// File: rtl/rs485_pkg.sv
// Shared types and constants for the RS-485 frame scheduler.
package rs485_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PRE,
    ST_LOAD,
    ST_SEND,
    ST_WAIT,
    ST_POST
  } state_e;

  // Position of the byte currently being sent within the frame.
  typedef enum logic [2:0] {
    IDX_SYNC,
    IDX_ID,
    IDX_LEN,
    IDX_PL,
    IDX_CHK
  } idx_e;

  localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;
  // One bit time at 19200 baud from a 50 MHz clock.
  localparam int         BPS_CYCLES    = 2604;

endpackage

// File: rtl/rs485_rr_arb2.sv
// Two-requester round-robin arbiter; sel=1 means requester 1 wins.
module rs485_rr_arb2 (
  input  logic clk,
  input  logic rst_n,
  input  logic req0,
  input  logic req1,
  input  logic take,
  output logic any,
  output logic sel
);

  logic last_grant;

  // Lone requester wins; on contention the one not granted last time wins.
  always_comb begin
    any = req0 | req1;
    if (req0 && req1) sel = ~last_grant;
    else              sel = req1;
  end

  // Remember the most recent winner; reset to 1 so requester 0 wins first.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    last_grant <= 1'b1;
    else if (take) last_grant <= sel;
  end

endmodule

// File: rtl/rs485_frame_sched.sv
// Frame scheduler: arbitrates two requesters, frames SYNC/ID/LEN/payload/XOR
// and feeds the byte transmitter while driving DE with pre/post guard times.
//
// state | meaning
// IDLE  | DE low, waiting for a request while the transmitter is ready
// PRE   | DE high, counting the leading guard time
// LOAD  | select the next frame byte, register it, fold it into the checksum
// SEND  | byte strobe high for one cycle
// WAIT  | waiting for the transmitter to finish the byte
// POST  | DE high, counting the trailing guard time
module rs485_frame_sched
  import rs485_pkg::*;
#(
  parameter logic [7:0] SYNC_BYTE  = SYNC_BYTE_DEF,
  parameter int         GUARD_PRE  = BPS_CYCLES,
  parameter int         GUARD_POST = BPS_CYCLES,
  parameter int         GW         = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req0,
  input  logic       req1,
  input  logic [7:0] id0,
  input  logic [7:0] id1,
  input  logic [7:0] len0,
  input  logic [7:0] len1,
  input  logic [7:0] data0,
  input  logic [7:0] data1,
  output logic       pl_rd0,
  output logic       pl_rd1,
  output logic       gnt0,
  output logic       gnt1,
  output logic       done0,
  output logic       done1,
  output logic       tx_din_vld,
  output logic [7:0] tx_din,
  input  logic       tx_rdy,
  output logic       de,
  output logic       busy
);

  localparam logic [GW-1:0] PRE_LOAD  = GW'(GUARD_PRE - 1);
  localparam logic [GW-1:0] POST_LOAD = GW'(GUARD_POST - 1);

  state_e        state, state_nxt;
  idx_e          idx, idx_nxt;
  logic [7:0]    pl_idx, pl_idx_nxt;
  logic [7:0]    id_q, id_nxt, len_q, len_nxt, chk_q, chk_nxt;
  logic          src_q, src_nxt;
  logic [GW-1:0] gcnt, gcnt_nxt;
  logic          de_nxt, vld_nxt, gnt0_nxt, gnt1_nxt, done0_nxt, done1_nxt;
  logic [7:0]    din_nxt, byte_sel;
  logic          arb_any, arb_sel, take;

  rs485_rr_arb2 u_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .req0  (req0),
    .req1  (req1),
    .take  (take),
    .any   (arb_any),
    .sel   (arb_sel)
  );

  assign busy = (state != ST_IDLE);

  // Next-state, datapath updates and the combinational payload pop strobes.
  always_comb begin
    state_nxt  = state;
    idx_nxt    = idx;
    pl_idx_nxt = pl_idx;
    id_nxt     = id_q;
    len_nxt    = len_q;
    chk_nxt    = chk_q;
    src_nxt    = src_q;
    gcnt_nxt   = gcnt;
    de_nxt     = de;
    din_nxt    = tx_din;
    vld_nxt    = 1'b0;
    gnt0_nxt   = 1'b0;
    gnt1_nxt   = 1'b0;
    done0_nxt  = 1'b0;
    done1_nxt  = 1'b0;
    take       = 1'b0;
    pl_rd0     = 1'b0;
    pl_rd1     = 1'b0;

    case (idx)
      IDX_SYNC: byte_sel = SYNC_BYTE;
      IDX_ID:   byte_sel = id_q;
      IDX_LEN:  byte_sel = len_q;
      IDX_PL:   byte_sel = src_q ? data1 : data0;
      default:  byte_sel = chk_q;
    endcase

    case (state)
      ST_IDLE: begin
        if (arb_any && tx_rdy) begin
          take       = 1'b1;
          gnt0_nxt   = ~arb_sel;
          gnt1_nxt   = arb_sel;
          src_nxt    = arb_sel;
          id_nxt     = arb_sel ? id1 : id0;
          len_nxt    = arb_sel ? len1 : len0;
          chk_nxt    = 8'h00;
          idx_nxt    = IDX_SYNC;
          pl_idx_nxt = 8'h00;
          gcnt_nxt   = PRE_LOAD;
          de_nxt     = 1'b1;
          state_nxt  = ST_PRE;
        end
      end
      ST_PRE: begin
        if (gcnt == '0) state_nxt = ST_LOAD;
        else            gcnt_nxt  = gcnt - 1'b1;
      end
      ST_LOAD: begin
        din_nxt = byte_sel;
        vld_nxt = 1'b1;
        if (idx inside {IDX_ID, IDX_LEN, IDX_PL}) chk_nxt = chk_q ^ byte_sel;
        if (idx == IDX_PL) begin
          pl_rd0 = ~src_q;
          pl_rd1 = src_q;
        end
        state_nxt = ST_SEND;
      end
      ST_SEND: state_nxt = ST_WAIT;
      ST_WAIT: begin
        if (tx_rdy) begin
          if (idx == IDX_CHK) begin
            gcnt_nxt  = POST_LOAD;
            state_nxt = ST_POST;
          end else begin
            state_nxt = ST_LOAD;
            case (idx)
              IDX_SYNC: idx_nxt = IDX_ID;
              IDX_ID:   idx_nxt = IDX_LEN;
              IDX_LEN: begin
                idx_nxt    = (len_q == 8'h00) ? IDX_CHK : IDX_PL;
                pl_idx_nxt = 8'h00;
              end
              default: begin
                if (pl_idx == len_q - 8'd1) idx_nxt    = IDX_CHK;
                else                        pl_idx_nxt = pl_idx + 8'd1;
              end
            endcase
          end
        end
      end
      ST_POST: begin
        if (gcnt == '0) begin
          de_nxt    = 1'b0;
          done0_nxt = ~src_q;
          done1_nxt = src_q;
          state_nxt = ST_IDLE;
        end else begin
          gcnt_nxt = gcnt - 1'b1;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // State and registered outputs; reset drops DE at once and clears the frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      idx        <= IDX_SYNC;
      pl_idx     <= 8'h00;
      id_q       <= 8'h00;
      len_q      <= 8'h00;
      chk_q      <= 8'h00;
      src_q      <= 1'b0;
      gcnt       <= '0;
      de         <= 1'b0;
      tx_din     <= 8'h00;
      tx_din_vld <= 1'b0;
      gnt0       <= 1'b0;
      gnt1       <= 1'b0;
      done0      <= 1'b0;
      done1      <= 1'b0;
    end else begin
      state      <= state_nxt;
      idx        <= idx_nxt;
      pl_idx     <= pl_idx_nxt;
      id_q       <= id_nxt;
      len_q      <= len_nxt;
      chk_q      <= chk_nxt;
      src_q      <= src_nxt;
      gcnt       <= gcnt_nxt;
      de         <= de_nxt;
      tx_din     <= din_nxt;
      tx_din_vld <= vld_nxt;
      gnt0       <= gnt0_nxt;
      gnt1       <= gnt1_nxt;
      done0      <= done0_nxt;
      done1      <= done1_nxt;
    end
  end

endmodule

// File: tb/tb_rs485_frame_sched.sv
// Bench for rs485_frame_sched with short guard times and a fast byte transmitter.
module tb_rs485_frame_sched;

  localparam int GP  = 8;
  localparam int GQ  = 8;
  localparam int BIT = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req0 = 1'b0, req1 = 1'b0;
  logic [7:0] id0 = 8'h00, id1 = 8'h00, len0 = 8'h00, len1 = 8'h00;
  logic [7:0] data0, data1;
  logic       pl_rd0, pl_rd1, gnt0, gnt1, done0, done1;
  logic       tx_din_vld, tx_rdy, de, busy;
  logic [7:0] tx_din;

  always #5 clk = ~clk;

  rs485_frame_sched #(.GUARD_PRE(GP), .GUARD_POST(GQ)) dut (
    .clk(clk), .rst_n(rst_n), .req0(req0), .req1(req1),
    .id0(id0), .id1(id1), .len0(len0), .len1(len1),
    .data0(data0), .data1(data1), .pl_rd0(pl_rd0), .pl_rd1(pl_rd1),
    .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
    .tx_din_vld(tx_din_vld), .tx_din(tx_din), .tx_rdy(tx_rdy),
    .de(de), .busy(busy)
  );

  // Byte transmitter model: 10 bit periods per byte, ready low during its strobe.
  logic xbusy;
  int   xcnt;
  assign tx_rdy = !xbusy && !tx_din_vld;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      xbusy <= 1'b0;
      xcnt  <= 0;
    end else if (xbusy) begin
      if (xcnt == 0) xbusy <= 1'b0;
      else           xcnt  <= xcnt - 1;
    end else if (tx_din_vld) begin
      xbusy <= 1'b1;
      xcnt  <= 10 * BIT - 1;
    end
  end

  // Show-ahead payload FIFOs for each requester.
  logic [7:0] mem0 [0:1023];
  logic [7:0] mem1 [0:1023];
  int rp0 = 0, rp1 = 0;
  assign data0 = mem0[rp0];
  assign data1 = mem1[rp1];
  always @(posedge clk) begin
    if (pl_rd0) rp0 <= rp0 + 1;
    if (pl_rd1) rp1 <= rp1 + 1;
  end

  int total = 0, bad = 0;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard and monitor state.
  logic [7:0] exp_q[$];
  bit         gnt_log[$];
  int         cyc = 0, de_rise_cyc = 0, rdy_rise_cyc = 0;
  bit         prev_de = 0, prev_vld = 0, prev_rdy = 1, prev_busy = 0, pend = 0;
  logic [7:0] first_byte = 8'h00, last_byte = 8'h00;
  int         done_cnt = 0, pl_cnt0 = 0, pl_cnt1 = 0, last_done_src = -1;
  bit         m_s;
  logic [7:0] m_id, m_len, m_b, m_c;

  // Sample on the falling edge: build expected frames at grant, check bytes and guard timing.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_de = 0; prev_vld = 0; prev_rdy = 1; prev_busy = 0; pend = 0;
    end else begin
      cyc++;
      if (gnt0 || gnt1) begin
        chk("gnt_onehot", int'(gnt0 & gnt1), 0);
        m_s = gnt1;
        gnt_log.push_back(m_s);
        m_id  = m_s ? id1 : id0;
        m_len = m_s ? len1 : len0;
        exp_q.push_back(8'hA5);
        exp_q.push_back(m_id);
        exp_q.push_back(m_len);
        m_c = m_id ^ m_len;
        for (int i = 0; i < int'(m_len); i++) begin
          m_b = m_s ? mem1[rp1 + i] : mem0[rp0 + i];
          exp_q.push_back(m_b);
          m_c = m_c ^ m_b;
        end
        exp_q.push_back(m_c);
      end
      if (de && !prev_de) begin
        chk("idle_gap", int'(prev_busy), 0);
        de_rise_cyc = cyc;
        pend = 1;
      end
      if (tx_din_vld) begin
        chk("vld_while_tx_busy", int'(xbusy), 0);
        chk("vld_back_to_back", int'(prev_vld), 0);
        if (exp_q.size() == 0) chk("tx_byte_extra", exp_q.size(), 1);
        else                   chk("tx_byte", int'(tx_din), int'(exp_q.pop_front()));
        last_byte = tx_din;
        if (pend) begin
          chk("guard_pre", cyc - de_rise_cyc, GP + 1);
          first_byte = tx_din;
          pend = 0;
        end
      end
      if (tx_rdy && !prev_rdy && de) rdy_rise_cyc = cyc;
      if (!de && prev_de) begin
        chk("guard_post", cyc - rdy_rise_cyc, GQ + 1);
        chk("done_at_de_fall", int'(done0 | done1), 1);
        chk("frame_bytes_left", exp_q.size(), 0);
      end
      if (done0 || done1) begin
        done_cnt++;
        last_done_src = done1 ? 1 : 0;
      end
      if (pl_rd0) pl_cnt0++;
      if (pl_rd1) pl_cnt1++;
      prev_de   = de;
      prev_vld  = tx_din_vld;
      prev_rdy  = tx_rdy;
      prev_busy = busy;
    end
  end

  typedef struct {
    bit         src;
    logic [7:0] id;
    logic [7:0] len;
    logic [7:0] pl [4];
    logic [7:0] exp_chk;
  } vec_t;

  vec_t vecs [4];

  task automatic setv(input int i, input bit s, input logic [7:0] id, input logic [7:0] ln,
                      input logic [7:0] p0, input logic [7:0] p1, input logic [7:0] p2,
                      input logic [7:0] p3, input logic [7:0] c);
    vecs[i].src = s; vecs[i].id = id; vecs[i].len = ln;
    vecs[i].pl[0] = p0; vecs[i].pl[1] = p1; vecs[i].pl[2] = p2; vecs[i].pl[3] = p3;
    vecs[i].exp_chk = c;
  endtask

  task automatic wait_gnt(input string name);
    int k = 0;
    while (!(gnt0 || gnt1) && k < 500) begin @(negedge clk); k++; end
    chk(name, int'(gnt0 || gnt1), 1);
  endtask

  task automatic wait_done(input int target, input string name);
    int k = 0;
    while (done_cnt < target && k < 3000) begin @(negedge clk); k++; end
    chk(name, int'(done_cnt >= target), 1);
  endtask

  initial begin
    int s, ln, pc0, pc1, d, g, k;
    setv(0, 1'b0, 8'h11, 8'd2, 8'h22, 8'h33, 8'h00, 8'h00, 8'h02);
    setv(1, 1'b1, 8'h40, 8'd0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h40);
    setv(2, 1'b0, 8'h5A, 8'd3, 8'h01, 8'h02, 8'h03, 8'h00, 8'h59);
    setv(3, 1'b1, 8'hFF, 8'd1, 8'h80, 8'h00, 8'h00, 8'h00, 8'h7E);

    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_de", int'(de), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_vld", int'(tx_din_vld), 0);
    chk("rst_din", int'(tx_din), 0);
    chk("rst_gnt", int'(gnt0 | gnt1), 0);
    chk("rst_done", int'(done0 | done1), 0);
    chk("rst_pl_rd", int'(pl_rd0 | pl_rd1), 0);

    for (int i = 0; i < 4; i++) begin
      s  = int'(vecs[i].src);
      ln = int'(vecs[i].len);
      for (int j = 0; j < ln; j++) begin
        if (s == 1) mem1[rp1 + j] = vecs[i].pl[j];
        else        mem0[rp0 + j] = vecs[i].pl[j];
      end
      if (s == 1) begin id1 = vecs[i].id; len1 = vecs[i].len; req1 = 1'b1; end
      else        begin id0 = vecs[i].id; len0 = vecs[i].len; req0 = 1'b1; end
      wait_gnt("gnt_timeout");
      chk("gnt_src", int'(gnt1), s);
      req0 = 1'b0; req1 = 1'b0;
      pc0 = pl_cnt0; pc1 = pl_cnt1; d = done_cnt;
      wait_done(d + 1, "done_timeout");
      chk("done_src", last_done_src, s);
      chk("pl_rd_cnt", (s == 1) ? pl_cnt1 - pc1 : pl_cnt0 - pc0, ln);
      chk("pl_rd_other", (s == 1) ? pl_cnt0 - pc0 : pl_cnt1 - pc1, 0);
      chk("frame_chk", int'(last_byte), int'(vecs[i].exp_chk));
      @(negedge clk);
    end

    // Both requesters held continuously: grants alternate starting with 0.
    id0 = 8'h01; len0 = 8'd0; id1 = 8'h02; len1 = 8'd0;
    g = gnt_log.size(); d = done_cnt;
    req0 = 1'b1; req1 = 1'b1;
    k = 0;
    while (gnt_log.size() < g + 4 && k < 3000) begin @(negedge clk); k++; end
    req0 = 1'b0; req1 = 1'b0;
    chk("cont_timeout", int'(gnt_log.size() >= g + 4), 1);
    wait_done(d + 4, "cont_done_timeout");
    chk("cont_gnt_count", gnt_log.size(), g + 4);
    for (int j = 0; j < 4; j++)
      if (gnt_log.size() > g + j) chk("cont_order", int'(gnt_log[g + j]), j % 2);

    // Reset while the first payload byte of a 5-byte frame is being strobed.
    for (int j = 0; j < 5; j++) mem0[rp0 + j] = 8'hA1 + 8'(j);
    id0 = 8'h33; len0 = 8'd5; req0 = 1'b1;
    wait_gnt("rst_gnt_timeout");
    req0 = 1'b0;
    k = 0;
    while (!pl_rd0 && k < 500) begin @(negedge clk); k++; end
    chk("rst_plrd_timeout", int'(pl_rd0), 1);
    @(negedge clk);
    chk("rst_vld_before", int'(tx_din_vld), 1);
    d = done_cnt;
    #1 rst_n = 1'b0;
    #1;
    chk("async_rst_de", int'(de), 0);
    chk("async_rst_busy", int'(busy), 0);
    chk("async_rst_vld", int'(tx_din_vld), 0);
    exp_q.delete();
    repeat (2) @(negedge clk);
    chk("rst_no_done", done_cnt, d);
    rst_n = 1'b1;
    @(negedge clk);

    // Recovery frame: fresh SYNC and a checksum starting from zero.
    mem0[rp0] = 8'h10;
    id0 = 8'h77; len0 = 8'd1; req0 = 1'b1;
    wait_gnt("recov_gnt_timeout");
    chk("recov_gnt_src", int'(gnt1), 0);
    req0 = 1'b0;
    wait_done(d + 1, "recov_done_timeout");
    chk("recov_sync", int'(first_byte), 8'hA5);
    chk("recov_chk", int'(last_byte), 8'h66);
    chk("recov_done_cnt", done_cnt, d + 1);

    repeat (4) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
